// File: rtl/imm_field_decode_if.sv
// imm_field_decode_if: upstream/downstream handshake bundle for imm_field_decode_stage; out_illegal exists only with IMM_ILLEGAL_DETECT_EN
interface imm_field_decode_if #(
  parameter int XLEN = 32,
  parameter int IMM_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_instr;
  logic [XLEN-1:0]  out_pc;
  logic [IMM_W-1:0] out_imm12;
  logic [1:0]       out_imm_type;
`ifdef IMM_ILLEGAL_DETECT_EN
  logic             out_illegal;
`endif
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm12, out_imm_type
`ifdef IMM_ILLEGAL_DETECT_EN
    , output out_illegal
`endif
  );
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm12, out_imm_type
`ifdef IMM_ILLEGAL_DETECT_EN
    , input out_illegal
`endif
  );
endinterface

// File: rtl/imm_field_decode_stage.sv
// imm_field_decode_stage: IF/ID register with 2-entry skid buffer and immediate-format classification; IMM_ILLEGAL_DETECT_EN adds out_illegal
module imm_field_decode_stage #(
  parameter int XLEN = 32,
  parameter int IMM_W = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  imm_field_decode_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [IMM_W-1:0] imm12;
    logic [1:0]       imm_type;
`ifdef IMM_ILLEGAL_DETECT_EN
    logic             illegal;
`endif
  } ent_t;
  ent_t main_q, skid_q, dec;
  logic main_valid, skid_valid;
  logic [6:0] op;
  logic is_i, is_s, is_b, acc, load_main;
  assign op = bus.in_instr[6:0];
  assign is_i = op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111;
  assign is_s = op == 7'b0100011;
  assign is_b = op == 7'b1100011;
  assign acc = bus.in_valid & ~skid_valid;
  assign load_main = ~main_valid | bus.out_ready;
  // classify the incoming instruction so the entry is stored already decoded
  always_comb begin
    dec.instr = bus.in_instr;
    dec.pc = bus.in_pc;
    dec.imm_type = is_b ? 2'b11 : is_s ? 2'b10 : is_i ? 2'b01 : 2'b00;
    dec.imm12 = is_i ? bus.in_instr[31:20]
              : is_s ? {bus.in_instr[31:25], bus.in_instr[11:7]}
              : is_b ? {bus.in_instr[31], bus.in_instr[7], bus.in_instr[30:25], bus.in_instr[11:8]}
              : '0;
`ifdef IMM_ILLEGAL_DETECT_EN
    dec.illegal = bus.in_instr[1:0] != 2'b11 || !(op inside {7'b0110111, 7'b0010111, 7'b1101111,
                  7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
                  7'b0001111, 7'b1110011});
`endif
  end
  // main refills from skid first, else from input; skid only catches input while main is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_main) begin
      main_valid <= skid_valid | acc;
      skid_valid <= 1'b0;
      if (skid_valid) main_q <= skid_q;
      else if (acc) main_q <= dec;
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_q <= dec;
    end
  end
  assign bus.in_ready = ~skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.out_instr = main_q.instr;
  assign bus.out_pc = main_q.pc;
  assign bus.out_imm12 = main_q.imm12;
  assign bus.out_imm_type = main_q.imm_type;
`ifdef IMM_ILLEGAL_DETECT_EN
  assign bus.out_illegal = main_q.illegal;
`endif
endmodule

// File: tb/tb_imm_field_decode_stage.sv
// tb_imm_field_decode_stage: table-driven scoreboard bench for imm_field_decode_stage
module tb_imm_field_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;
  imm_field_decode_if #(.XLEN(32), .IMM_W(12)) bus ();
  imm_field_decode_stage #(.XLEN(32), .IMM_W(12)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [11:0] imm;
    logic [1:0]  ty;
    logic        ill;
  } vec_t;
  vec_t tbl [13];
  vec_t q[$];
  vec_t cur;
  int total = 0;
  int bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic mon();
    vec_t e;
    if (!rst_n || flush) q.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("unexpected_out", {32'h0, bus.out_instr}, 64'hdead);
        else begin
          e = q.pop_front();
          chk("out_instr", {32'h0, bus.out_instr}, {32'h0, e.instr});
          chk("out_pc", {32'h0, bus.out_pc}, {32'h0, e.pc});
          chk("out_imm12", {52'h0, bus.out_imm12}, {52'h0, e.imm});
          chk("out_imm_type", {62'h0, bus.out_imm_type}, {62'h0, e.ty});
`ifdef IMM_ILLEGAL_DETECT_EN
          chk("out_illegal", {63'h0, bus.out_illegal}, {63'h0, e.ill});
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(cur);
    end
  endtask
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input vec_t v);
    cur = v;
    bus.in_valid = 1'b1;
    bus.in_instr = v.instr;
    bus.in_pc = v.pc;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_out_valid"}, {63'h0, bus.out_valid}, 64'h0);
    chk({tag, "_in_ready"}, {63'h0, bus.in_ready}, 64'h1);
    chk({tag, "_zero_data"}, {bus.out_instr, bus.out_pc}, 64'h0);
    chk({tag, "_zero_imm"}, {50'h0, bus.out_imm12, bus.out_imm_type}, 64'h0);
`ifdef IMM_ILLEGAL_DETECT_EN
    chk({tag, "_zero_ill"}, {63'h0, bus.out_illegal}, 64'h0);
`endif
  endtask
  initial begin
    tbl[0]  = '{32'hFFF00093, 32'h1000, 12'hFFF, 2'b01, 1'b0};
    tbl[1]  = '{32'hFE112E23, 32'h1004, 12'hFFC, 2'b10, 1'b0};
    tbl[2]  = '{32'hFE000EE3, 32'h1008, 12'hFFE, 2'b11, 1'b0};
    tbl[3]  = '{32'h00402083, 32'h100C, 12'h004, 2'b01, 1'b0};
    tbl[4]  = '{32'h008080E7, 32'h1010, 12'h008, 2'b01, 1'b0};
    tbl[5]  = '{32'h00000033, 32'h1014, 12'h000, 2'b00, 1'b0};
    tbl[6]  = '{32'h0000007F, 32'h1018, 12'h000, 2'b00, 1'b1};
    tbl[7]  = '{32'h12345037, 32'h101C, 12'h000, 2'b00, 1'b0};
    tbl[8]  = '{32'h00000001, 32'h1020, 12'h000, 2'b00, 1'b1};
    tbl[9]  = '{32'h7FF00013, 32'h1024, 12'h7FF, 2'b01, 1'b0};
    tbl[10] = '{32'h80002023, 32'h1028, 12'h800, 2'b10, 1'b0};
    tbl[11] = '{32'h80000063, 32'h102C, 12'h800, 2'b11, 1'b0};
    tbl[12] = '{32'h0000006F, 32'h1030, 12'h000, 2'b00, 1'b0};
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;
    cur = '0;
    #2;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      step();
      chk("latency_valid", {63'h0, bus.out_valid}, 64'h1);
      chk("latency_instr", {32'h0, bus.out_instr}, {32'h0, tbl[i].instr});
    end
    bus.in_valid = 1'b0;
    step();
    step();
    chk("stream_drained", q.size(), 0);
    bus.out_ready = 1'b0;
    drive(tbl[0]);
    step();
    drive(tbl[1]);
    step();
    drive(tbl[2]);
    chk("bp_in_ready_low", {63'h0, bus.in_ready}, 64'h0);
    step();
    chk("bp_still_low", {63'h0, bus.in_ready}, 64'h0);
    chk("bp_hold_instr", {32'h0, bus.out_instr}, {32'h0, tbl[0].instr});
    bus.out_ready = 1'b1;
    step();
    chk("bp_ready_back", {63'h0, bus.in_ready}, 64'h1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("bp_drained", q.size(), 0);
    chk("bp_empty", {63'h0, bus.out_valid}, 64'h0);
    bus.out_ready = 1'b0;
    drive(tbl[3]);
    step();
    drive(tbl[4]);
    step();
    drive(tbl[5]);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("flush_in_ready", {63'h0, bus.in_ready}, 64'h1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("flush_stays_empty", {63'h0, bus.out_valid}, 64'h0);
    bus.out_ready = 1'b0;
    drive(tbl[9]);
    step();
    drive(tbl[10]);
    step();
    bus.in_valid = 1'b0;
    chk("pre_reset_valid", {63'h0, bus.out_valid}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("reset_no_replay", {63'h0, bus.out_valid}, 64'h0);
    drive(tbl[11]);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("final_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
